uart_rx_pkt_ctrl: RTL and testbench

//  Packet controller downstream of the UART receiver. Consumes the receiver's byte strobe,

---
 rtl/uart_rx_pkt_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet controller behind a UART receiver: hunts for SYNC/LEN/payload/CHK frames,
// buffers and verifies each payload, then streams it out on a valid/ready interface.
module uart_rx_pkt_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_frame_error,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic       pkt_last,
    output logic       pkt_done,
    output logic       pkt_err,
    output logic [2:0] err_code,
    output logic       busy
);

    localparam int PW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAX_LEN_B  = 8'(MAX_LEN);

    localparam logic [2:0] E_FRAME   = 3'd1;
    localparam logic [2:0] E_LEN     = 3'd2;
    localparam logic [2:0] E_CHKSUM  = 3'd3;
    localparam logic [2:0] E_TIMEOUT = 3'd4;
    localparam logic [2:0] E_OVERRUN = 3'd5;

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHECK,
        S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic            rxv_prev_q, rxv_prev_d;
    logic            ferr_prev_q, ferr_prev_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      sum_q, sum_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      pkt_data_q, pkt_data_d;
    logic            pkt_valid_q, pkt_valid_d;
    logic            pkt_last_q, pkt_last_d;
    logic            pkt_done_q, pkt_done_d;
    logic            pkt_err_q, pkt_err_d;
    logic [2:0]      err_code_q, err_code_d;
    logic            busy_q, busy_d;

    logic [7:0]      buf_q [MAX_LEN];
    logic            buf_we;

    logic            byte_ev, frame_ev, byte_acc, any_ev;
    logic [PW-1:0]   wr_next, rd_next;

    // A frame event in the same cycle as a byte event discards the byte.
    assign byte_ev  = rx_valid & ~rxv_prev_q;
    assign frame_ev = rx_frame_error & ~ferr_prev_q;
    assign byte_acc = byte_ev & ~frame_ev;
    assign any_ev   = byte_ev | frame_ev;
    assign wr_next  = wr_ptr_q + PW'(1);
    assign rd_next  = rd_ptr_q + PW'(1);

    always_comb begin
        state_d     = state_q;
        rxv_prev_d  = rx_valid;
        ferr_prev_d = rx_frame_error;
        len_d       = len_q;
        sum_d       = sum_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        timer_d     = timer_q;
        pkt_data_d  = pkt_data_q;
        pkt_valid_d = pkt_valid_q;
        pkt_last_d  = pkt_last_q;
        pkt_done_d  = 1'b0;
        pkt_err_d   = 1'b0;
        err_code_d  = err_code_q;
        buf_we      = 1'b0;

        case (state_q)
            S_HUNT: begin
                if (byte_acc && rx_data == SYNC_BYTE) begin
                    state_d = S_LEN;
                    timer_d = '0;
                end
            end
            S_LEN: begin
                if (frame_ev) begin
                    pkt_err_d  = 1'b1;
                    err_code_d = E_FRAME;
                    state_d    = S_HUNT;
                end else if (byte_acc) begin
                    len_d    = rx_data;
                    sum_d    = rx_data;
                    wr_ptr_d = '0;
                    timer_d  = '0;
                    if (rx_data == 8'd0) begin
                        state_d = S_CHECK;
                    end else if (rx_data > MAX_LEN_B) begin
                        pkt_err_d  = 1'b1;
                        err_code_d = E_LEN;
                        state_d    = S_HUNT;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    pkt_err_d  = 1'b1;
                    err_code_d = E_TIMEOUT;
                    state_d    = S_HUNT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_PAYLOAD: begin
                if (frame_ev) begin
                    pkt_err_d  = 1'b1;
                    err_code_d = E_FRAME;
                    state_d    = S_HUNT;
                end else if (byte_acc) begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_next;
                    sum_d    = sum_q + rx_data;
                    timer_d  = '0;
                    if (8'(wr_next) == len_q) begin
                        state_d = S_CHECK;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    pkt_err_d  = 1'b1;
                    err_code_d = E_TIMEOUT;
                    state_d    = S_HUNT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_CHECK: begin
                if (frame_ev) begin
                    pkt_err_d  = 1'b1;
                    err_code_d = E_FRAME;
                    state_d    = S_HUNT;
                end else if (byte_acc) begin
                    timer_d = '0;
                    if (rx_data == sum_q) begin
                        state_d  = S_DRAIN;
                        rd_ptr_d = '0;
                        // Present the first byte right away so the stream starts on DRAIN entry.
                        if (len_q != 8'd0) begin
                            pkt_valid_d = 1'b1;
                            pkt_data_d  = buf_q[0];
                            pkt_last_d  = (len_q == 8'd1);
                        end
                    end else begin
                        pkt_err_d  = 1'b1;
                        err_code_d = E_CHKSUM;
                        state_d    = S_HUNT;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    pkt_err_d  = 1'b1;
                    err_code_d = E_TIMEOUT;
                    state_d    = S_HUNT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DRAIN: begin
                // Incoming traffic cannot be accepted while draining; flag it and keep going.
                if (any_ev) begin
                    pkt_err_d  = 1'b1;
                    err_code_d = E_OVERRUN;
                end
                if (len_q == 8'd0) begin
                    pkt_done_d = 1'b1;
                    state_d    = S_HUNT;
                end else if (pkt_valid_q && pkt_ready) begin
                    if (pkt_last_q) begin
                        pkt_valid_d = 1'b0;
                        pkt_last_d  = 1'b0;
                        pkt_done_d  = 1'b1;
                        state_d     = S_HUNT;
                    end else begin
                        rd_ptr_d   = rd_next;
                        pkt_data_d = buf_q[rd_next[AW-1:0]];
                        pkt_last_d = ((8'(rd_next) + 8'd1) == len_q);
                    end
                end
            end
            default: state_d = S_HUNT;
        endcase

        busy_d = (state_d != S_HUNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_HUNT;
            rxv_prev_q  <= 1'b1;
            ferr_prev_q <= 1'b1;
            len_q       <= '0;
            sum_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            timer_q     <= '0;
            pkt_data_q  <= '0;
            pkt_valid_q <= 1'b0;
            pkt_last_q  <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_err_q   <= 1'b0;
            err_code_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rxv_prev_q  <= rxv_prev_d;
            ferr_prev_q <= ferr_prev_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            timer_q     <= timer_d;
            pkt_data_q  <= pkt_data_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_last_q  <= pkt_last_d;
            pkt_done_q  <= pkt_done_d;
            pkt_err_q   <= pkt_err_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[wr_ptr_q[AW-1:0]] <= rx_data;
        end
    end

    assign pkt_data  = pkt_data_q;
    assign pkt_valid = pkt_valid_q;
    assign pkt_last  = pkt_last_q;
    assign pkt_done  = pkt_done_q;
    assign pkt_err   = pkt_err_q;
    assign err_code  = err_code_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Self-checking bench for uart_rx_pkt_ctrl: table vectors, directed corner sequences and
// randomized packets checked against a packet-level expectation built from the framing rules.
module tb_uart_rx_pkt_ctrl;
    localparam int MAX_LEN = 16;
    localparam int TMO     = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_error;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_ready;
    logic       pkt_last;
    logic       pkt_done;
    logic       pkt_err;
    logic [2:0] err_code;
    logic       busy;

    uart_rx_pkt_ctrl #(
        .SYNC_BYTE(8'hA5),
        .MAX_LEN(MAX_LEN),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_frame_error(rx_frame_error),
        .pkt_data(pkt_data),
        .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready),
        .pkt_last(pkt_last),
        .pkt_done(pkt_done),
        .pkt_err(pkt_err),
        .err_code(err_code),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] got_data[$];
    bit         got_last[$];
    int         got_done;
    int         got_err[$];
    logic [7:0] exp_data[$];
    bit         exp_last[$];
    int         exp_done;
    int         exp_err[$];
    bit         rand_ready = 1'b0;

    typedef struct {
        int         nb;
        logic [7:0] b [8];
        int         nd;
        logic [7:0] d [4];
        int         ndone;
        int         ecode;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) pkt_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        tick();
        rx_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic clear_mon();
        got_data.delete(); got_last.delete(); got_err.delete(); got_done = 0;
        exp_data.delete(); exp_last.delete(); exp_err.delete(); exp_done = 0;
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        while ((busy || pkt_valid) && k < max) begin
            tick();
            k++;
        end
        check("idle_wait", int'(busy || pkt_valid), 0);
        repeat (3) tick();
    endtask

    task automatic compare_seg(input string name);
        check({name, "_ndata"}, got_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size(); i++) begin
            if (i < got_data.size()) begin
                check($sformatf("%s_data%0d", name, i), int'(got_data[i]), int'(exp_data[i]));
                check($sformatf("%s_last%0d", name, i), int'(got_last[i]), int'(exp_last[i]));
            end
        end
        check({name, "_done"}, got_done, exp_done);
        check({name, "_nerr"}, got_err.size(), exp_err.size());
        for (int i = 0; i < exp_err.size(); i++) begin
            if (i < got_err.size()) check($sformatf("%s_err%0d", name, i), got_err[i], exp_err[i]);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_data"}, int'(pkt_data), 0);
        check({name, "_valid"}, int'(pkt_valid), 0);
        check({name, "_last"}, int'(pkt_last), 0);
        check({name, "_done"}, int'(pkt_done), 0);
        check({name, "_err"}, int'(pkt_err), 0);
        check({name, "_code"}, int'(err_code), 0);
        check({name, "_busy"}, int'(busy), 0);
    endtask

    // Expected outcome per packet follows directly from the framing rules.
    task automatic gen_packet(input int kind, input int len);
        int         s;
        logic [7:0] pl [16];
        logic [7:0] junk;
        if ($urandom_range(0, 2) == 0) begin
            junk = 8'($urandom_range(0, 255));
            if (junk == 8'hA5) junk = 8'h00;
            send_byte(junk);
        end
        send_byte(8'hA5);
        if (kind == 2) begin
            send_byte(8'($urandom_range(MAX_LEN + 1, 255)));
            exp_err.push_back(2);
        end else begin
            send_byte(8'(len));
            s = len;
            for (int i = 0; i < len; i++) begin
                pl[i] = 8'($urandom_range(0, 255));
                s += int'(pl[i]);
                send_byte(pl[i]);
            end
            if (kind == 0) begin
                send_byte(8'(s % 256));
                for (int i = 0; i < len; i++) begin
                    exp_data.push_back(pl[i]);
                    exp_last.push_back(i == len - 1);
                end
                exp_done++;
            end else begin
                send_byte(8'(s % 256) ^ 8'($urandom_range(1, 255)));
                exp_err.push_back(3);
            end
        end
        wait_idle(400);
    endtask

    // Output monitor and stall-stability checker
    initial begin
        bit         stall_prev = 1'b0;
        logic [7:0] stall_data = '0;
        logic       stall_last = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", int'(pkt_valid), 1);
                    check("hold_data", int'(pkt_data), int'(stall_data));
                    check("hold_last", int'(pkt_last), int'(stall_last));
                end
                stall_prev = pkt_valid && !pkt_ready;
                stall_data = pkt_data;
                stall_last = pkt_last;
                if (pkt_valid && pkt_ready) begin
                    got_data.push_back(pkt_data);
                    got_last.push_back(pkt_last);
                end
                if (pkt_done) got_done++;
                if (pkt_err) got_err.push_back(int'(err_code));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{nb: 6, b: '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69, 8'h00, 8'h00},
                    nd: 3, d: '{8'h11, 8'h22, 8'h33, 8'h00}, ndone: 1, ecode: 0};
        vecs[1] = '{nb: 5, b: '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00},
                    nd: 0, d: '{8'h00, 8'h00, 8'h00, 8'h00}, ndone: 0, ecode: 3};
        vecs[2] = '{nb: 4, b: '{8'hA5, 8'h01, 8'h07, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00},
                    nd: 1, d: '{8'h07, 8'h00, 8'h00, 8'h00}, ndone: 1, ecode: 0};
        vecs[3] = '{nb: 2, b: '{8'hA5, 8'h14, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    nd: 0, d: '{8'h00, 8'h00, 8'h00, 8'h00}, ndone: 0, ecode: 2};
        vecs[4] = '{nb: 3, b: '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    nd: 0, d: '{8'h00, 8'h00, 8'h00, 8'h00}, ndone: 1, ecode: 0};
        vecs[5] = '{nb: 6, b: '{8'h3C, 8'hA5, 8'h02, 8'hA5, 8'h5A, 8'h01, 8'h00, 8'h00},
                    nd: 2, d: '{8'hA5, 8'h5A, 8'h00, 8'h00}, ndone: 1, ecode: 0};
        vecs[6] = '{nb: 2, b: '{8'hA5, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    nd: 0, d: '{8'h00, 8'h00, 8'h00, 8'h00}, ndone: 0, ecode: 2};

        reset = 1'b1; rx_data = '0; rx_valid = 1'b0; rx_frame_error = 1'b0; pkt_ready = 1'b1;
        clear_mon();
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 7; i++) begin
            clear_mon();
            for (int j = 0; j < vecs[i].nb; j++) send_byte(vecs[i].b[j]);
            wait_idle(200);
            for (int j = 0; j < vecs[i].nd; j++) begin
                exp_data.push_back(vecs[i].d[j]);
                exp_last.push_back(j == vecs[i].nd - 1);
            end
            exp_done = vecs[i].ndone;
            if (vecs[i].ecode != 0) exp_err.push_back(vecs[i].ecode);
            compare_seg($sformatf("vec%0d", i));
        end

        // Oversize LEN: error and idle visible the cycle after the LEN byte
        send_byte(8'hA5);
        rx_data = 8'h14; rx_valid = 1'b1;
        tick();
        check("len_err_pulse", int'(pkt_err), 1);
        check("len_err_code", int'(err_code), 2);
        check("len_busy", int'(busy), 0);
        tick(); rx_valid = 1'b0; repeat (3) tick();

        // Timeout fires exactly TMO cycles after the last byte event
        send_byte(8'hA5);
        send_byte(8'h02);
        rx_data = 8'h44; rx_valid = 1'b1;
        tick(); tick(); rx_valid = 1'b0;
        repeat (TMO - 2) tick();
        check("tmo_early_err", int'(pkt_err), 0);
        check("tmo_early_busy", int'(busy), 1);
        tick();
        check("tmo_err_pulse", int'(pkt_err), 1);
        check("tmo_err_code", int'(err_code), 4);
        check("tmo_busy", int'(busy), 0);
        repeat (3) tick();

        // A byte arriving right at the timeout limit is still accepted
        clear_mon();
        send_byte(8'hA5);
        rx_data = 8'h01; rx_valid = 1'b1;
        tick(); tick(); rx_valid = 1'b0;
        repeat (TMO - 2) tick();
        check("tmo_edge_busy", int'(busy), 1);
        send_byte(8'h09);
        send_byte(8'h0A);
        wait_idle(100);
        exp_data.push_back(8'h09); exp_last.push_back(1'b1); exp_done = 1;
        compare_seg("tmo_edge");

        // Frame error right after SYNC
        send_byte(8'hA5);
        rx_frame_error = 1'b1;
        tick();
        check("frm_err_pulse", int'(pkt_err), 1);
        check("frm_err_code", int'(err_code), 1);
        check("frm_busy", int'(busy), 0);
        rx_frame_error = 1'b0; repeat (2) tick();

        // Simultaneous byte and frame events in PAYLOAD: frame wins, byte dropped
        clear_mon();
        send_byte(8'hA5);
        send_byte(8'h02);
        rx_data = 8'h77; rx_valid = 1'b1; rx_frame_error = 1'b1;
        tick();
        check("both_err_code", int'(err_code), 1);
        check("both_busy", int'(busy), 0);
        tick(); rx_valid = 1'b0; rx_frame_error = 1'b0; repeat (3) tick();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h07); send_byte(8'h08);
        wait_idle(100);
        exp_data.push_back(8'h07); exp_last.push_back(1'b1); exp_done = 1; exp_err.push_back(1);
        compare_seg("both");

        // Overrun during a stalled drain
        clear_mon();
        pkt_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h67);
        check("ovr_valid", int'(pkt_valid), 1);
        check("ovr_data0", int'(pkt_data), 8'hAA);
        check("ovr_last0", int'(pkt_last), 0);
        rx_data = 8'h55; rx_valid = 1'b1;
        tick();
        check("ovr_err_pulse", int'(pkt_err), 1);
        check("ovr_err_code", int'(err_code), 5);
        check("ovr_still_valid", int'(pkt_valid), 1);
        check("ovr_still_data", int'(pkt_data), 8'hAA);
        tick(); rx_valid = 1'b0;
        repeat (12) tick();
        pkt_ready = 1'b1;
        wait_idle(100);
        exp_data.push_back(8'hAA); exp_last.push_back(1'b0);
        exp_data.push_back(8'hBB); exp_last.push_back(1'b1);
        exp_done = 1; exp_err.push_back(5);
        compare_seg("ovr");

        // Reset mid-PAYLOAD with rx_valid rising and held through reset
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h01); send_byte(8'h02);
        reset = 1'b1; rx_data = 8'hA5; rx_valid = 1'b1;
        tick();
        check_all_zero("rst_payload");
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("rst_no_event_busy", int'(busy), 0);
        rx_valid = 1'b0; tick();

        // Reset mid-DRAIN
        pkt_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h33); send_byte(8'h34);
        check("rst_drain_pre_valid", int'(pkt_valid), 1);
        reset = 1'b1;
        tick();
        check_all_zero("rst_drain");
        reset = 1'b0; pkt_ready = 1'b1;
        tick();
        clear_mon();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        wait_idle(100);
        exp_done = 1;
        compare_seg("rst_len0");

        // Randomized packets with random backpressure
        clear_mon();
        rand_ready = 1'b1;
        gen_packet(0, MAX_LEN);
        gen_packet(0, 1);
        for (int p = 0; p < 25; p++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) gen_packet(0, int'($urandom_range(0, MAX_LEN)));
            else if (r < 8) gen_packet(1, int'($urandom_range(0, MAX_LEN)));
            else gen_packet(2, 0);
        end
        rand_ready = 1'b0;
        pkt_ready = 1'b1;
        compare_seg("rand");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
